cla_seq_adder_ctrl: RTL and testbench

Multi-cycle N-bit adder/subtractor that time-shares one 4-bit carry-lookahead slice over successive nibbles, LSB first. It accepts operands over a valid/ready handshake, sequences the slice once per cycle while holding the inter-nibble carry in a register, and returns sum, carry-out and signed overflow over a second valid/ready handshake. It sits beside the arithmetic datapath as the area-lean alternative to a full-width CLA tree.

---
 rtl/cla_seq_adder_ctrl_pkg.sv | 17 +
 rtl/cla_seq_adder_ctrl_slice.sv | 45 ++++
 rtl/cla_seq_adder_ctrl.sv | 134 +++++++++++++
 tb/tb_cla_seq_adder_ctrl.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/cla_seq_adder_ctrl_pkg.sv
// Shared types and helpers for the nibble-serial carry-lookahead adder.
// Holds the controller state encoding and the nibble index width function.
package cla_seq_adder_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_t;

   // A one-nibble datapath still needs a 1-bit index register.
   function automatic int idx_w(input int nib);
      if (nib <= 1) return 1;
      return $clog2(nib);
   endfunction

endpackage

// File: rtl/cla_seq_adder_ctrl_slice.sv
// Combinational 4-bit carry-lookahead slice: g/p generation, lookahead carry
// generator, and the per-bit sum. Time-shared by the controller.
module cla4_gen (
   input  logic [3:0] g,
   input  logic [3:0] p,
   input  logic       ci,
   output logic [3:0] c,
   output logic       co
);
   // c[i] is the carry into bit i, fully flattened so no carry ripples.
   assign c[0] = ci;
   assign c[1] = g[0] | (p[0] & ci);
   assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
   assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
               | (p[2] & p[1] & p[0] & ci);
   assign co   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
               | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & ci);
endmodule

module cla4_slice (
   input  logic [3:0] a_n,
   input  logic [3:0] b_n,
   input  logic       ci,
   output logic [3:0] s,
   output logic       co,
   output logic       c3
);
   logic [3:0] g;
   logic [3:0] p;
   logic [3:0] c;

   assign g = a_n & b_n;
   assign p = a_n ^ b_n;

   cla4_gen u_gen (
      .g  (g),
      .p  (p),
      .ci (ci),
      .c  (c),
      .co (co)
   );

   assign s  = p ^ c;
   assign c3 = c[3];
endmodule

// File: rtl/cla_seq_adder_ctrl.sv
// Multi-cycle adder/subtractor: one 4-bit CLA slice walks the operands LSB
// nibble first, with the inter-nibble carry held in a register.
module cla_seq_adder_ctrl
   import cla_seq_adder_ctrl_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);
   localparam int NIB   = WIDTH / 4;
   localparam int IDX_W = idx_w(NIB);

   generate
      if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_bad_width
         $error("cla_seq_adder_ctrl: WIDTH must be a multiple of 4 and >= 4");
      end
   endgenerate

   state_t             state_reg, state_next;
   logic [WIDTH-1:0]   a_reg, a_next;
   logic [WIDTH-1:0]   b_reg, b_next;
   logic               carry_reg, carry_next;
   logic [IDX_W-1:0]   idx_reg, idx_next;
   logic [WIDTH-1:0]   sum_reg, sum_next;
   logic               cout_reg, cout_next;
   logic               ovf_reg, ovf_next;

   logic [3:0]         a_nib [NIB];
   logic [3:0]         b_nib [NIB];
   logic [3:0]         slice_s;
   logic               slice_co;
   logic               slice_c3;
   logic [WIDTH-1:0]   sum_wb;
   logic               last_nib;

   // Nibble view of the latched operands and the write-back image of the sum.
   generate
      for (genvar gi = 0; gi < NIB; gi++) begin : g_nib
         assign a_nib[gi] = a_reg[gi*4 +: 4];
         assign b_nib[gi] = b_reg[gi*4 +: 4];
         assign sum_wb[gi*4 +: 4] = (idx_reg == IDX_W'(gi)) ? slice_s
                                                            : sum_reg[gi*4 +: 4];
      end
   endgenerate

   cla4_slice u_slice (
      .a_n (a_nib[idx_reg]),
      .b_n (b_nib[idx_reg]),
      .ci  (carry_reg),
      .s   (slice_s),
      .co  (slice_co),
      .c3  (slice_c3)
   );

   assign last_nib = (idx_reg == IDX_W'(NIB - 1));

   always_comb begin
      state_next = state_reg;
      a_next     = a_reg;
      b_next     = b_reg;
      carry_next = carry_reg;
      idx_next   = idx_reg;
      sum_next   = sum_reg;
      cout_next  = cout_reg;
      ovf_next   = ovf_reg;
      case (state_reg)
         IDLE: begin
            if (in_valid) begin
               // Subtraction is A + ~B + 1; the +1 rides in on the carry.
               a_next     = a;
               b_next     = sub ? ~b : b;
               carry_next = sub ? 1'b1 : cin;
               idx_next   = '0;
               state_next = RUN;
            end
         end
         RUN: begin
            sum_next   = sum_wb;
            carry_next = slice_co;
            idx_next   = idx_reg + 1'b1;
            if (last_nib) begin
               cout_next  = slice_co;
               ovf_next   = slice_c3 ^ slice_co;
               state_next = DONE;
            end
         end
         DONE: begin
            if (out_ready) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
         a_reg     <= '0;
         b_reg     <= '0;
         carry_reg <= 1'b0;
         idx_reg   <= '0;
         sum_reg   <= '0;
         cout_reg  <= 1'b0;
         ovf_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         a_reg     <= a_next;
         b_reg     <= b_next;
         carry_reg <= carry_next;
         idx_reg   <= idx_next;
         sum_reg   <= sum_next;
         cout_reg  <= cout_next;
         ovf_reg   <= ovf_next;
      end
   end

   assign in_ready  = (state_reg == IDLE);
   assign out_valid = (state_reg == DONE);
   assign sum       = sum_reg;
   assign cout      = cout_reg;
   assign ovf       = ovf_reg;

endmodule

// File: tb/tb_cla_seq_adder_ctrl.sv
// Directed-vector bench for the nibble-serial adder at WIDTH=16.
// Each vector carries hand-computed sum, carry-out and overflow.
module tb_cla_seq_adder_ctrl;
   localparam int WIDTH = 16;
   localparam int NIB   = WIDTH / 4;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;

   int n_vec  = 0;
   int n_miss = 0;

   cla_seq_adder_ctrl #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .ovf       (ovf)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end else begin
         $display("ok   %s: %0h", tag, got);
      end
   endtask

   // Wait for out_valid after an accept edge; returns ticks taken.
   task automatic wait_done(input string tag, output int n);
      n = 0;
      while (!out_valid && n < 20) begin
         tick();
         n++;
      end
      chk({tag, "_lat"}, 32'(n + 1), 32'(NIB + 1));
   endtask

   task automatic run_op(input string tag, input logic [15:0] ta, input logic [15:0] tb_v,
                         input logic tcin, input logic tsub, input logic [15:0] esum,
                         input logic ecout, input logic eovf, input int hold);
      int n;
      chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
      a = ta; b = tb_v; cin = tcin; sub = tsub; in_valid = 1'b1;
      tick();
      // Operand changes after acceptance must not disturb the result.
      in_valid = 1'b0; a = 16'hDEAD; b = 16'hBEEF; cin = 1'b1; sub = 1'b1;
      wait_done(tag, n);
      chk({tag, "_sum"}, 32'(sum), 32'(esum));
      chk({tag, "_cout"}, 32'(cout), 32'(ecout));
      chk({tag, "_ovf"}, 32'(ovf), 32'(eovf));
      for (int i = 0; i < hold; i++) begin
         tick();
         chk({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
         chk({tag, "_hold_sum"}, 32'(sum), 32'(esum));
         chk({tag, "_hold_in_ready"}, 32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk({tag, "_idle_valid"}, 32'(out_valid), 32'd0);
      chk({tag, "_idle_in_ready"}, 32'(in_ready), 32'd1);
      chk({tag, "_idle_sum_held"}, 32'(sum), 32'(esum));
   endtask

   initial begin
      int n;
      int gap;
      rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
      out_ready = 1'b0;
      tick();
      tick();
      // rst wins over a simultaneous request.
      a = 16'h1111; b = 16'h2222; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      rst = 1'b0;
      chk("reset_in_ready", 32'(in_ready), 32'd1);
      chk("reset_out_valid", 32'(out_valid), 32'd0);
      chk("reset_sum", 32'(sum), 32'd0);
      chk("reset_cout", 32'(cout), 32'd0);
      chk("reset_ovf", 32'(ovf), 32'd0);
      tick();
      chk("rst_beats_valid", 32'(in_ready), 32'd1);

      run_op("ripple",   16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 0);
      run_op("add_cin",  16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0, 0);
      run_op("sub_ovf",  16'h7FFF, 16'hFFFF, 1'b1, 1'b1, 16'h8000, 1'b0, 1'b1, 0);
      run_op("bkpress",  16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0, 3);

      // Abort on the second RUN cycle.
      a = 16'hAAAA; b = 16'h5555; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("abort_in_ready", 32'(in_ready), 32'd1);
      chk("abort_out_valid", 32'(out_valid), 32'd0);
      chk("abort_sum", 32'(sum), 32'd0);
      chk("abort_cout", 32'(cout), 32'd0);
      run_op("post_abort", 16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0, 0);

      // Back-to-back with in_valid and out_ready held high.
      out_ready = 1'b1;
      a = 16'h0003; b = 16'h0004; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
      tick();
      a = 16'h8000; b = 16'h8000;
      wait_done("b2b_first", n);
      chk("b2b_first_sum", 32'(sum), 32'h0007);
      chk("b2b_first_cout", 32'(cout), 32'd0);
      gap = n;
      n = 0;
      while (!in_ready && n < 20) begin
         tick();
         n++;
      end
      gap = gap + n + 1;
      chk("b2b_accept_gap", 32'(gap), 32'(NIB + 2));
      tick();
      in_valid = 1'b0;
      wait_done("b2b_second", n);
      chk("b2b_second_sum", 32'(sum), 32'h0000);
      chk("b2b_second_cout", 32'(cout), 32'd1);
      chk("b2b_second_ovf", 32'(ovf), 32'd1);
      tick();
      out_ready = 1'b0;
      chk("b2b_final_in_ready", 32'(in_ready), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule
